// File: rtl/mat5_mult_seq.sv
// Sequential 5x5 signed fixed-point matrix multiplier C = A x B, one element per handshake in and out.
// Define MAT5_SAT_EN to saturate results to DW bits and report clamping on ovf; otherwise results wrap.
module mat5_mult_seq #(
    parameter int DW   = 32,
    parameter int FRAC = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [2:0]    out_row,
    output logic [2:0]    out_col,
    output logic          out_last,
    output logic          busy,
    output logic          ovf
);

    localparam int ACCW = 2*DW + 3;

    typedef enum logic [1:0] {ST_LOAD, ST_MAC, ST_OUT} state_t;

    state_t                 state_q, state_d;
    logic [5:0]             idx_q, idx_d;
    logic [2:0]             i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [DW-1:0]          out_data_q, out_data_d;
    logic [2:0]             out_row_q, out_row_d, out_col_q, out_col_d;
    logic                   out_last_q, out_last_d;
    logic                   ovf_q, ovf_d;

    // Operands 0..24 hold A row-major, 25..49 hold B row-major.
    logic [DW-1:0] mem [0:49];

    logic [5:0]               a_idx, b_idx;
    logic signed [DW-1:0]     a_op, b_op;
    logic signed [2*DW-1:0]   prod;
    logic signed [ACCW-1:0]   acc_sum, shifted;
    logic [DW-1:0]            res;
    logic                     sat;

    assign a_idx   = 6'(i_q) * 6'd5 + 6'(k_q);
    assign b_idx   = 6'd25 + 6'(k_q) * 6'd5 + 6'(j_q);
    assign a_op    = $signed(mem[a_idx]);
    assign b_op    = $signed(mem[b_idx]);
    assign prod    = a_op * b_op;
    assign acc_sum = acc_q + {{3{prod[2*DW-1]}}, prod};
    assign shifted = acc_sum >>> FRAC;

`ifdef MAT5_SAT_EN
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    always_comb begin
        res = shifted[DW-1:0];
        sat = 1'b0;
        if (shifted > SAT_MAX) begin
            res = SAT_MAX[DW-1:0];
            sat = 1'b1;
        end else if (shifted < SAT_MIN) begin
            res = SAT_MIN[DW-1:0];
            sat = 1'b1;
        end
    end
`else
    logic unused_hi;
    assign res       = shifted[DW-1:0];
    assign sat       = 1'b0;
    assign unused_hi = ^shifted[ACCW-1:DW];
`endif

    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD && in_valid)
            mem[idx_q] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD;
            idx_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_row_q  <= '0;
            out_col_q  <= '0;
            out_last_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_row_q  <= out_row_d;
            out_col_q  <= out_col_d;
            out_last_q <= out_last_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_row_d  = out_row_q;
        out_col_d  = out_col_q;
        out_last_d = out_last_q;
        ovf_d      = ovf_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    idx_d = idx_q + 6'd1;
                    if (idx_q == 6'd0)
                        ovf_d = 1'b0;
                    if (idx_q == 6'd49) begin
                        idx_d   = '0;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = ST_MAC;
                    end
                end
            end
            ST_MAC: begin
                acc_d = acc_sum;
                k_d   = k_q + 3'd1;
                // The final product is folded straight into the registered result.
                if (k_q == 3'd4) begin
                    out_data_d = res;
                    out_row_d  = i_q;
                    out_col_d  = j_q;
                    out_last_d = (i_q == 3'd4) && (j_q == 3'd4);
                    if (sat)
                        ovf_d = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = ST_MAC;
                    if (out_last_q) begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end else if (j_q == 3'd4) begin
                        j_d = '0;
                        i_d = i_q + 3'd1;
                    end else begin
                        j_d = j_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_LOAD);
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;
    assign ovf       = ovf_q;

endmodule
